// File: rtl/tap_sweep_controller.sv
// Sweeps every delay tap through a load/settle/clear/observe handshake with the flag_generator and reports the longest clean window.
// Latency: 1+SETTLE_CYCLES+CLEAR_CYCLES+SAMPLE_CYCLES+1 cycles per tap; done one cycle after the last tap evaluation. Optional macro: TAP_SWEEP_CENTER_EN.
// Backpressure: none; start is ignored while busy and the flag is sampled unconditionally once per tap.
module tap_sweep_controller #(
    parameter int TAP_WIDTH     = 5,
    parameter int MAX_TAP       = 31,
    parameter int SETTLE_CYCLES = 8,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_WINDOW    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flag,
    output logic                 clear_flags,
    output logic [TAP_WIDTH-1:0] tap_value,
    output logic                 tap_load,
    output logic                 busy,
    output logic                 done,
    output logic                 window_found,
    output logic [TAP_WIDTH-1:0] window_start,
    output logic [TAP_WIDTH-1:0] window_end
);

    localparam int CNT_MAX_SC = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SC > SAMPLE_CYCLES) ? CNT_MAX_SC : SAMPLE_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int LEN_W      = TAP_WIDTH + 1;

`ifdef TAP_SWEEP_CENTER_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_OBSERVE, S_EVAL, S_DONE, S_CENTER
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_OBSERVE, S_EVAL, S_DONE
    } state_t;
`endif

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [LEN_W-1:0]     cur_len;
    logic [LEN_W-1:0]     best_len;
    logic [TAP_WIDTH-1:0] cur_start;
    logic [TAP_WIDTH-1:0] best_start;
    logic [TAP_WIDTH-1:0] best_end;

    // Run bookkeeping for the tap being evaluated this cycle.
    logic                 clean;
    logic [LEN_W-1:0]     cur_len_inc;
    logic [TAP_WIDTH-1:0] run_start;
    logic                 take;
    logic [LEN_W-1:0]     best_len_n;
    logic [TAP_WIDTH-1:0] best_start_n;
    logic [TAP_WIDTH-1:0] best_end_n;

    always_comb begin
        clean        = ~flag;
        cur_len_inc  = cur_len + LEN_W'(1);
        run_start    = (cur_len == '0) ? tap_value : cur_start;
        take         = clean && (cur_len_inc > best_len);
        best_len_n   = take ? cur_len_inc : best_len;
        best_start_n = take ? run_start   : best_start;
        best_end_n   = take ? tap_value   : best_end;
    end

`ifdef TAP_SWEEP_CENTER_EN
    logic [TAP_WIDTH:0] center_sum;
    assign center_sum = {1'b0, window_start} + {1'b0, window_end};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cur_len      <= '0;
            best_len     <= '0;
            cur_start    <= '0;
            best_start   <= '0;
            best_end     <= '0;
            clear_flags  <= 1'b0;
            tap_value    <= '0;
            tap_load     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            window_found <= 1'b0;
            window_start <= '0;
            window_end   <= '0;
        end else begin
            tap_load <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        tap_value    <= '0;
                        tap_load     <= 1'b1;
                        busy         <= 1'b1;
                        cur_len      <= '0;
                        best_len     <= '0;
                        cur_start    <= '0;
                        best_start   <= '0;
                        best_end     <= '0;
                        window_found <= 1'b0;
                        window_start <= '0;
                        window_end   <= '0;
                    end
                end
                S_LOAD: begin
                    state <= S_SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state       <= S_CLEAR;
                        cnt         <= CNT_W'(CLEAR_CYCLES - 1);
                        clear_flags <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (cnt == '0) begin
                        state       <= S_OBSERVE;
                        cnt         <= CNT_W'(SAMPLE_CYCLES - 1);
                        clear_flags <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_OBSERVE: begin
                    if (cnt == '0) begin
                        state <= S_EVAL;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    cur_len    <= clean ? cur_len_inc : '0;
                    cur_start  <= run_start;
                    best_len   <= best_len_n;
                    best_start <= best_start_n;
                    best_end   <= best_end_n;
                    if (tap_value == TAP_WIDTH'(MAX_TAP)) begin
                        // Results are published straight from the next-state best values.
                        state        <= S_DONE;
                        window_found <= (best_len_n >= LEN_W'(MIN_WINDOW));
                        window_start <= best_start_n;
                        window_end   <= best_end_n;
`ifndef TAP_SWEEP_CENTER_EN
                        busy         <= 1'b0;
                        done         <= 1'b1;
`endif
                    end else begin
                        state     <= S_LOAD;
                        tap_value <= tap_value + TAP_WIDTH'(1);
                        tap_load  <= 1'b1;
                    end
                end
`ifdef TAP_SWEEP_CENTER_EN
                S_DONE: begin
                    tap_load <= 1'b1;
                    done     <= 1'b1;
                    if (window_found) begin
                        state     <= S_CENTER;
                        tap_value <= center_sum[TAP_WIDTH:1];
                    end else begin
                        state     <= S_IDLE;
                        tap_value <= '0;
                        busy      <= 1'b0;
                    end
                end
                S_CENTER: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
`else
                S_DONE: begin
                    state <= S_IDLE;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_sweep_controller.sv
// Table-driven and randomized checks of tap_sweep_controller timing, window selection and reset behaviour.
module tb_tap_sweep_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       flag  = 1'b1;
    logic       flag3 = 1'b1;
    logic       clear_flags, tap_load, busy, done, window_found;
    logic [4:0] tap_value, window_start, window_end;
    logic       clear_flags3, tap_load3, busy3, done3, window_found3;
    logic [4:0] tap_value3, window_start3, window_end3;

    int checks = 0;
    int errors = 0;
    logic [31:0] noisy;

    always #5 clock = ~clock;

    tap_sweep_controller dut (
        .clock(clock), .reset(reset), .start(start), .flag(flag),
        .clear_flags(clear_flags), .tap_value(tap_value), .tap_load(tap_load),
        .busy(busy), .done(done), .window_found(window_found),
        .window_start(window_start), .window_end(window_end)
    );

    tap_sweep_controller #(.MIN_WINDOW(3)) dut3 (
        .clock(clock), .reset(reset), .start(start), .flag(flag3),
        .clear_flags(clear_flags3), .tap_value(tap_value3), .tap_load(tap_load3),
        .busy(busy3), .done(done3), .window_found(window_found3),
        .window_start(window_start3), .window_end(window_end3)
    );

    typedef struct {
        logic [31:0] noisy;
        bit          f4;
        int          ws;
        int          we;
        bit          f3;
    } vec_t;

    typedef struct {
        bit found;
        int s;
        int e;
    } res_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Longest all-clean span over every (start,end) pair; earliest start wins ties.
    function automatic res_t model(input logic [31:0] nm, input int minw);
        res_t r;
        int best;
        logic [63:0] span;
        best = 0; r.s = 0; r.e = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = a; b < 32; b++) begin
                span = ((64'd1 << (b - a + 1)) - 64'd1) << a;
                if ((({32'd0, nm}) & span) == 64'd0 && (b - a + 1) > best) begin
                    best = b - a + 1; r.s = a; r.e = b;
                end
            end
        end
        r.found = (best >= minw);
        return r;
    endfunction

    task automatic drive_flags();
        flag  = noisy[tap_value];
        flag3 = noisy[tap_value3];
    endtask

    task automatic run_sweep(input string tag, input logic [31:0] nm, input bit exp_f, input int exp_s,
                             input int exp_e, input bit exp_f3, input bit mid_start);
        int bad_load, bad_clr, bad_busy, bad_done, bad_tap, ph;
        bit e_load, e_clr, e_busy, e_done;
        int e_tap;
        bad_load = 0; bad_clr = 0; bad_busy = 0; bad_done = 0; bad_tap = 0;
        noisy = nm;
        drive_flags();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 900; c++) begin
            ph     = (c - 1) % 28;
            e_load = (c <= 896) && (ph == 0);
            e_clr  = (c <= 896) && (ph == 9 || ph == 10);
            e_busy = (c <= 896);
            e_done = (c == 897);
            e_tap  = (c <= 896) ? (c - 1) / 28 : 31;
            if (tap_load != e_load || tap_load3 != e_load) bad_load++;
            if (clear_flags != e_clr || clear_flags3 != e_clr) bad_clr++;
            if (busy != e_busy || busy3 != e_busy) bad_busy++;
            if (done != e_done || done3 != e_done) bad_done++;
            if (int'(tap_value) != e_tap) bad_tap++;
            if (c == 897) begin
                chk({tag, " found"}, int'(window_found), int'(exp_f));
                chk({tag, " start"}, int'(window_start), exp_s);
                chk({tag, " end"}, int'(window_end), exp_e);
                chk({tag, " found_min3"}, int'(window_found3), int'(exp_f3));
                chk({tag, " start_min3"}, int'(window_start3), exp_s);
            end
            start = (mid_start && c == 300) ? 1'b1 : 1'b0;
            drive_flags();
            @(negedge clock);
        end
        chk({tag, " tap_load_timing_bad_cycles"}, bad_load, 0);
        chk({tag, " clear_flags_timing_bad_cycles"}, bad_clr, 0);
        chk({tag, " busy_timing_bad_cycles"}, bad_busy, 0);
        chk({tag, " done_timing_bad_cycles"}, bad_done, 0);
        chk({tag, " tap_value_bad_cycles"}, bad_tap, 0);
        chk({tag, " end_held"}, int'(window_end), exp_e);
    endtask

    initial begin
        vec_t vecs[6];
        res_t r4, r3;
        logic [31:0] m;
        int waited;

        vecs[0] = '{~32'h001F_FC00, 1'b1, 10, 20, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF,  1'b0, 0,  0,  1'b0};
        vecs[2] = '{~32'h0070_0038, 1'b0, 3,  5,  1'b1};
        vecs[3] = '{32'h0000_0000,  1'b1, 0,  31, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF,  1'b0, 31, 31, 1'b0};
        vecs[5] = '{~32'hF000_000F, 1'b1, 0,  3,  1'b1};

        noisy = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);
        chk("reset busy", int'(busy), 0);
        chk("reset clear_flags", int'(clear_flags), 0);
        chk("reset tap_value", int'(tap_value), 0);
        chk("reset tap_load", int'(tap_load), 0);
        chk("reset done", int'(done), 0);
        chk("reset window_found", int'(window_found), 0);

        // Start coincident with reset must be dropped.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("start_with_reset busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].noisy, vecs[i].f4, vecs[i].ws,
                      vecs[i].we, vecs[i].f3, (i == 0));
        end

        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: m = $urandom;
                1: m = $urandom & $urandom & $urandom;
                default: m = $urandom | $urandom;
            endcase
            r4 = model(m, 4);
            r3 = model(m, 3);
            run_sweep($sformatf("rand%0d", i), m, r4.found, r4.s, r4.e, r3.found, 1'b0);
        end

        // Abort mid-sweep while tap 7 is in CLEAR.
        noisy = 32'h0000_0000;
        drive_flags();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (!(tap_value == 5'd7 && clear_flags) && waited < 400) begin
            drive_flags();
            @(negedge clock);
            waited++;
        end
        chk("reach tap7 clear within bound", int'(waited < 400), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort clear_flags", int'(clear_flags), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort tap_value", int'(tap_value), 0);
        chk("abort done", int'(done), 0);
        reset = 1'b0;
        @(negedge clock);
        run_sweep("after_abort", vecs[0].noisy, vecs[0].f4, vecs[0].ws, vecs[0].we, vecs[0].f3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_sweep_controller.md
Name: tap_sweep_controller

Overview:
Training-side initiator that drives the flag_generator handshake during DDR read-capture calibration. For each delay tap it loads the tap, waits for the data to settle, pulses clear_flags, observes the flag, and records whether the tap is clean. After sweeping all taps it reports the longest contiguous clean window. It sits between the training sequencer and the per-lane flag_generator and delay line.

Parameters:
TAP_WIDTH, 5, width of the tap index
MAX_TAP, 31, last tap swept (inclusive); must be ≤ 2^TAP_WIDTH-1
SETTLE_CYCLES, 8, cycles waited after tap_load before clearing flags (≥1)
CLEAR_CYCLES, 2, cycles clear_flags is held high per tap (≥2, so the transition detector captures two samples)
SAMPLE_CYCLES, 16, observation cycles after clear_flags falls (≥1)
MIN_WINDOW, 4, minimum clean-run length for window_found

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
flag  in  1  flag from flag_generator (1 = noisy or transitioned)
clear_flags  out  1  clear/sample strobe to flag_generator
tap_value  out  TAP_WIDTH  delay tap currently applied
tap_load  out  1  one-cycle strobe: delay line loads tap_value
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the sweep completes
window_found  out  1  best run length ≥ MIN_WINDOW
window_start  out  TAP_WIDTH  first tap of the best clean run
window_end  out  TAP_WIDTH  last tap of the best clean run

Behaviour:
- Reset: the FSM enters IDLE and all outputs are 0. Internal counters, current run, and best run are cleared. Reset mid-sweep aborts the sweep, and clear_flags is low on the next cycle.
- States and transitions:
  - IDLE: on start, go to LOAD. Set tap=0, set busy=1, clear run and best registers, and clear window_* outputs.
  - LOAD: assert tap_load for 1 cycle, then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to CLEAR.
  - CLEAR: hold clear_flags=1 for CLEAR_CYCLES cycles, then go to OBSERVE.
  - OBSERVE: clear_flags=0; count SAMPLE_CYCLES cycles, then go to EVAL.
  - EVAL: a 1-cycle state that samples flag.
    - flag=0 (clean): if cur_len==0, set cur_start=tap. Increment cur_len. If the new cur_len > best_len (strictly), set best_start=cur_start, best_end=tap, best_len=new cur_len.
    - flag=1: cur_len=0.
    - If tap==MAX_TAP, go to DONE; otherwise tap=tap+1 and go to LOAD.
  - DONE: done=1 for 1 cycle. busy=0, and window_start/window_end/window_found update from the best registers this cycle. Then go to IDLE.
- Per-tap period: 1 + SETTLE_CYCLES + CLEAR_CYCLES + SAMPLE_CYCLES + 1 cycles (28 at defaults). A full default sweep therefore takes 32×28 = 896 cycles, with done in the cycle after the last EVAL.
- Tie rule: the first window found wins, because updates require strictly greater length.
- No clean tap: window_found=0, window_start=window_end=0.
- Results hold until the next start or reset.
- start while busy is ignored. start coincident with reset: reset wins.
- Counters are sized for the largest parameter; tap never wraps past MAX_TAP.
- cur_len and best_len are TAP_WIDTH+1 bits wide, so a full-range run of MAX_TAP+1 taps is representable.

Optional Feature:
TAP_SWEEP_CENTER_EN
- Defined: DONE is followed by a CENTER state, reached only if window_found=1. CENTER drives tap_value=(window_start+window_end)>>1 (floor) with tap_load=1 for one cycle. done is then asserted one cycle later than without the feature, and busy stays high through CENTER. If window_found=0, the FSM goes straight from DONE to IDLE and tap_value=0 is reloaded with tap_load=1.
- Undefined: no CENTER state. tap_value holds MAX_TAP after the sweep and no post-sweep tap_load is issued.

Test Plan:
- Bench drives flag=0 for taps 10..20 and 1 elsewhere, then pulses start → done after 896 cycles; window_start=10, window_end=20, window_found=1 (with CENTER_EN: final tap_load with tap_value=15).
- flag=1 at every tap → window_found=0, window_start=window_end=0, done pulses exactly once.
- Clean taps 3..5 and 20..22 (equal length 3) with MIN_WINDOW=3 → window_start=3, window_end=5, window_found=1; with MIN_WINDOW=4 → window_found=0.
- All taps clean → window_start=0, window_end=31, best_len=32 without overflow.
- Handshake timing check: per tap, tap_load is high 1 cycle, then exactly 8 cycles later clear_flags is high for exactly 2 cycles, then 16 low cycles before the EVAL sample. A start pulse issued mid-sweep is ignored.
- reset asserted while tap_value=7 in CLEAR → next cycle clear_flags=0, busy=0, tap_value=0, done=0; a fresh start then sweeps correctly from tap 0.
